pc_unit: RTL and testbench

//   Program counter and interrupt-vector unit for the Von Neumann processor.
//   - Consumes the 5-bit cs command, 8-bit pcontrol and 2-bit irq driven to/by the control FSM.
//   - Produces pcout, which is fed back to the control FSM and used as the memory fetch address.
//   - Holds a two-level return-address stack and the interrupt-nesting state.

---
 rtl/pc_unit.sv | 154 +++++++++++++++
 tb/tb_pc_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter, two-level return stack and interrupt-nesting FSM
module pc_unit #(
    parameter int               PC_W      = 8,
    parameter logic [PC_W-1:0]  RESET_VEC = 8'h00,
    parameter logic [PC_W-1:0]  VEC_A     = 8'hF0,
    parameter logic [PC_W-1:0]  VEC_B     = 8'hE0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      cs,
    input  logic [PC_W-1:0] pcontrol,
    input  logic [1:0]      irq,
    output logic [PC_W-1:0] pcout,
    output logic [1:0]      irq_ack,
    output logic            in_isr,
    output logic [1:0]      level,
    output logic            stack_err
);

    localparam logic [4:0] CS_SOFT_RST = 5'b11110;
    localparam logic [4:0] CS_INC      = 5'b11111;
    localparam logic [4:0] CS_JUMP     = 5'b11010;
    localparam logic [4:0] CS_ENTRY    = 5'b11100;
    localparam logic [4:0] CS_RETI     = 5'b11101;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ISR_B  = 2'd1,
        ISR_A  = 2'd2,
        ISR_AB = 2'd3
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_stack [2];
    logic [1:0]        r_irq_ack;
    logic [1:0]        r_level;
    logic              r_in_isr;
    logic              r_stack_err;

    state_t            w_state_next;
    logic [PC_W-1:0]   w_pc_next;
    logic              w_push;
    logic              w_err_set;
    logic [1:0]        w_ack;
    logic [1:0]        w_level_next;
    logic              w_soft_rst;
    logic              w_push_idx;
    logic              w_pop_idx;

    assign w_soft_rst = (cs == CS_SOFT_RST);
    // Stack depth equals nesting level: push goes to slot [level], pop reads slot [level-1].
    assign w_push_idx = r_level[0];
    assign w_pop_idx  = r_level[1];

    // Next-state, next-pc and side-effect decode from the current command.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        w_err_set    = 1'b0;
        w_ack        = 2'b00;
        case (cs)
            CS_INC:  w_pc_next = r_pc + 1'b1;
            CS_JUMP: w_pc_next = pcontrol;
            CS_ENTRY: begin
                // irq=11 resolves to A; irq=00 is a silent no-op in every state.
                case (r_state)
                    NORMAL: begin
                        if (irq[1]) begin
                            w_state_next = ISR_A;
                            w_pc_next    = VEC_A;
                            w_push       = 1'b1;
                            w_ack        = 2'b10;
                        end else if (irq[0]) begin
                            w_state_next = ISR_B;
                            w_pc_next    = VEC_B;
                            w_push       = 1'b1;
                            w_ack        = 2'b01;
                        end
                    end
                    ISR_B: begin
                        if (irq[1]) begin
                            w_state_next = ISR_AB;
                            w_pc_next    = VEC_A;
                            w_push       = 1'b1;
                            w_ack        = 2'b10;
                        end else if (irq[0]) begin
                            w_err_set = 1'b1;
                        end
                    end
                    default: begin
                        if (irq != 2'b00) w_err_set = 1'b1;
                    end
                endcase
            end
            CS_RETI: begin
                case (r_state)
                    NORMAL: w_err_set = 1'b1;
                    ISR_AB: begin
                        w_state_next = ISR_B;
                        w_pc_next    = r_stack[w_pop_idx];
                    end
                    default: begin
                        w_state_next = NORMAL;
                        w_pc_next    = r_stack[w_pop_idx];
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Nesting depth implied by the next state.
    always_comb begin
        w_level_next = 2'd0;
        case (w_state_next)
            NORMAL:  w_level_next = 2'd0;
            ISR_B:   w_level_next = 2'd1;
            ISR_A:   w_level_next = 2'd1;
            ISR_AB:  w_level_next = 2'd2;
            default: w_level_next = 2'd0;
        endcase
    end

    // State, pc, stack and registered outputs; hard or soft reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset || w_soft_rst) begin
            r_state     <= NORMAL;
            r_pc        <= RESET_VEC;
            r_stack[0]  <= '0;
            r_stack[1]  <= '0;
            r_irq_ack   <= 2'b00;
            r_level     <= 2'd0;
            r_in_isr    <= 1'b0;
            r_stack_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_irq_ack <= w_ack;
            r_level   <= w_level_next;
            r_in_isr  <= (w_level_next != 2'd0);
            if (w_push) r_stack[w_push_idx] <= r_pc;
            if (w_err_set) r_stack_err <= 1'b1;
        end
    end

    assign pcout     = r_pc;
    assign irq_ack   = r_irq_ack;
    assign in_isr    = r_in_isr;
    assign level     = r_level;
    assign stack_err = r_stack_err;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

    logic       clk;
    logic       reset;
    logic [4:0] cs;
    logic [7:0] pcontrol;
    logic [1:0] irq;
    logic [7:0] pcout;
    logic [1:0] irq_ack;
    logic       in_isr;
    logic [1:0] level;
    logic       stack_err;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] NOP  = 5'b00000;
    localparam logic [4:0] SRST = 5'b11110;
    localparam logic [4:0] INC  = 5'b11111;
    localparam logic [4:0] JMP  = 5'b11010;
    localparam logic [4:0] ENT  = 5'b11100;
    localparam logic [4:0] RETI = 5'b11101;

    pc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .pcontrol  (pcontrol),
        .irq       (irq),
        .pcout     (pcout),
        .irq_ack   (irq_ack),
        .in_isr    (in_isr),
        .level     (level),
        .stack_err (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one command at the falling edge, sample 1ns after the following rising edge.
    task automatic step(input logic r, input logic [4:0] c, input logic [1:0] q, input logic [7:0] p);
        @(negedge clk);
        reset    = r;
        cs       = c;
        irq      = q;
        pcontrol = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks pc, ack, level, in_isr and error flag in one go.
    task automatic chk_all(input string tag, input logic [7:0] pc, input logic [1:0] ack,
                           input logic [1:0] lv, input logic err);
        chk({tag, ".pc"},  pcout, pc);
        chk({tag, ".ack"}, {6'd0, irq_ack}, {6'd0, ack});
        chk({tag, ".lvl"}, {6'd0, level}, {6'd0, lv});
        chk({tag, ".isr"}, {7'd0, in_isr}, {7'd0, (lv != 2'd0)});
        chk({tag, ".err"}, {7'd0, stack_err}, {7'd0, err});
    endtask

    initial begin
        reset = 1'b1; cs = NOP; irq = 2'b00; pcontrol = 8'h00;

        // 1: reset held 2 cycles, then increment x3
        step(1, NOP, 2'b00, 8'h00);
        step(1, NOP, 2'b00, 8'h00);
        chk_all("rst", 8'h00, 2'b00, 2'd0, 1'b0);
        step(0, INC, 2'b00, 8'h00); chk_all("inc1", 8'h01, 2'b00, 2'd0, 1'b0);
        step(0, INC, 2'b00, 8'h00); chk_all("inc2", 8'h02, 2'b00, 2'd0, 1'b0);
        step(0, INC, 2'b00, 8'h00); chk_all("inc3", 8'h03, 2'b00, 2'd0, 1'b0);
        step(0, 5'b00101, 2'b00, 8'h77); chk_all("other_hold", 8'h03, 2'b00, 2'd0, 1'b0);

        // 2: wrap FF->00 without error
        step(0, JMP, 2'b00, 8'hFE); chk_all("jmp_fe", 8'hFE, 2'b00, 2'd0, 1'b0);
        step(0, INC, 2'b00, 8'h00); chk_all("wrap_ff", 8'hFF, 2'b00, 2'd0, 1'b0);
        step(0, INC, 2'b00, 8'h00); chk_all("wrap_00", 8'h00, 2'b00, 2'd0, 1'b0);
        step(0, INC, 2'b00, 8'h00); chk_all("wrap_01", 8'h01, 2'b00, 2'd0, 1'b0);

        // 3: A entry and return
        step(0, JMP, 2'b00, 8'h05); chk_all("jmp_05", 8'h05, 2'b00, 2'd0, 1'b0);
        step(0, ENT, 2'b10, 8'h00); chk_all("entA", 8'hF0, 2'b10, 2'd1, 1'b0);
        step(0, RETI, 2'b00, 8'h00); chk_all("retA", 8'h05, 2'b00, 2'd0, 1'b0);

        // 4: B entry, preemption by A (irq=11), nested returns
        step(0, JMP, 2'b00, 8'h07); chk_all("jmp_07", 8'h07, 2'b00, 2'd0, 1'b0);
        step(0, ENT, 2'b01, 8'h00); chk_all("entB", 8'hE0, 2'b01, 2'd1, 1'b0);
        step(0, INC, 2'b00, 8'h00); chk_all("isrB_inc", 8'hE1, 2'b00, 2'd1, 1'b0);
        step(0, ENT, 2'b11, 8'h00); chk_all("entAB", 8'hF0, 2'b10, 2'd2, 1'b0);
        step(0, RETI, 2'b00, 8'h00); chk_all("retAB", 8'hE1, 2'b00, 2'd1, 1'b0);
        step(0, RETI, 2'b00, 8'h00); chk_all("retB", 8'h07, 2'b00, 2'd0, 1'b0);

        // 5: ignored entry in ISR_A, RETI underflow, sticky error, soft reset
        step(0, ENT, 2'b10, 8'h00); chk_all("entA2", 8'hF0, 2'b10, 2'd1, 1'b0);
        step(0, ENT, 2'b01, 8'h00); chk_all("isrA_ignB", 8'hF0, 2'b00, 2'd1, 1'b1);
        step(0, RETI, 2'b00, 8'h00); chk_all("retA2", 8'h07, 2'b00, 2'd0, 1'b1);
        step(0, RETI, 2'b00, 8'h00); chk_all("underflow", 8'h07, 2'b00, 2'd0, 1'b1);
        step(0, ENT, 2'b00, 8'h00); chk_all("ent_noirq", 8'h07, 2'b00, 2'd0, 1'b1);
        step(0, SRST, 2'b00, 8'h00); chk_all("softrst", 8'h00, 2'b00, 2'd0, 1'b0);

        // ISR_B ignores a second B entry
        step(0, ENT, 2'b01, 8'h00); chk_all("entB2", 8'hE0, 2'b01, 2'd1, 1'b0);
        step(0, ENT, 2'b01, 8'h00); chk_all("isrB_ignB", 8'hE0, 2'b00, 2'd1, 1'b1);
        step(0, SRST, 2'b00, 8'h00); chk_all("softrst2", 8'h00, 2'b00, 2'd0, 1'b0);

        // 6: level 2, full-stack entry, then reset beats a jump
        step(0, JMP, 2'b00, 8'h10); chk_all("jmp_10", 8'h10, 2'b00, 2'd0, 1'b0);
        step(0, ENT, 2'b01, 8'h00); chk_all("entB3", 8'hE0, 2'b01, 2'd1, 1'b0);
        step(0, ENT, 2'b10, 8'h00); chk_all("entAB2", 8'hF0, 2'b10, 2'd2, 1'b0);
        step(0, ENT, 2'b10, 8'h00); chk_all("full_ign", 8'hF0, 2'b00, 2'd2, 1'b1);
        step(1, JMP, 2'b00, 8'h3C); chk_all("rst_jmp", 8'h00, 2'b00, 2'd0, 1'b0);
        step(0, INC, 2'b00, 8'h00); chk_all("post_rst", 8'h01, 2'b00, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
